// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes and FSM state encoding for the UART transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;
  localparam logic [2:0] ST_BREAK_ENC  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_START  = ST_START_ENC,
    S_DATA   = ST_DATA_ENC,
    S_PARITY = ST_PARITY_ENC,
    S_STOP   = ST_STOP_ENC,
    S_BREAK  = ST_BREAK_ENC
  } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - reloadable down-counter marking the last clk of each serial bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter; UART_TX_BREAK_EN adds a break generator.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
`ifdef UART_TX_BREAK_EN
  , parameter int BREAK_BITS = 13
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
`ifdef UART_TX_BREAK_EN
  , input logic                break_req
`endif
);

  localparam int BW = $clog2(DATA_BITS + 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_q, par_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 bit_end;

`ifdef UART_TX_BREAK_EN
  localparam int KW = $clog2(BREAK_BITS + 1);
  logic [KW-1:0] brk_cnt_q, brk_cnt_d;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;
    done_d     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d   = S_BREAK;
          brk_cnt_d = '0;
          load      = 1'b1;
        end else
`endif
        if (din_valid && ready_q) begin
          shift_d    = din;
          par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          par_d      = (^din) ^ (parity_mode == PAR_ODD);
          two_stop_d = two_stop;
          bit_cnt_d  = '0;
          state_d    = S_START;
          load       = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          load    = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          load    = 1'b1;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          load    = 1'b1;
        end
      end
      S_STOP: begin
        // bit_cnt counts completed stop bits; it is zero on entry
        if (bit_end) begin
          if (two_stop_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BW'(1);
            load      = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (bit_end) begin
          if (brk_cnt_q == KW'(BREAK_BITS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            brk_cnt_d = brk_cnt_q + KW'(1);
            load      = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from the next state so each bit lines up with its state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_q;
      S_BREAK:  tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_cnt_q <= '0;
    end else begin
      brk_cnt_q <= brk_cnt_d;
    end
  end
`endif

  assign tx        = tx_q;
  assign din_ready = ready_q;
  assign tx_done   = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed bench for uart_tx_cfg (8-bit/4-clk and 5-bit/2-clk instances).
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx, din_ready, busy, tx_done;
`ifdef UART_TX_BREAK_EN
  logic       brk_req;
  logic       b_brk;
`endif

  logic [4:0] b_din;
  logic       b_valid;
  logic [1:0] b_pm;
  logic       b_ts;
  logic       b_tx, b_ready, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  logic cap_tx   [0:127];
  logic cap_done [0:127];
  logic cap_rdy  [0:127];
  logic cap_busy [0:127];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
`ifdef UART_TX_BREAK_EN
    , .break_req (brk_req)
`endif
  );

  uart_tx_cfg #(.DATA_BITS(5), .CLKS_PER_BIT(2)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .din         (b_din),
    .din_valid   (b_valid),
    .din_ready   (b_ready),
    .parity_mode (b_pm),
    .two_stop    (b_ts),
    .tx          (b_tx),
    .busy        (b_busy),
    .tx_done     (b_done)
`ifdef UART_TX_BREAK_EN
    , .break_req (b_brk)
`endif
  );

  task automatic start_word(input logic [7:0] d, input logic [1:0] pm, input logic ts, input logic hold);
    int w = 0;
    while (din_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (din_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_wait: din_ready=%b expected 1", din_ready);
    end
    din = d; parity_mode = pm; two_stop = ts; din_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic capture(input int n, input int chg_idx, input logic [7:0] chg_din, input int drop_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i] = tx; cap_done[i] = tx_done; cap_rdy[i] = din_ready; cap_busy[i] = busy;
      if (i == chg_idx) din = chg_din;
      if (i == drop_idx) din_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int idle_bad = 0;
    #2;
    total++; if (tx !== 1'b1)        begin bad++; $display("FAIL rst_tx: got %b expected 1", tx); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", din_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++; if (tx_done !== 1'b0)   begin bad++; $display("FAIL rst_done: got %b expected 0", tx_done); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_pre: got %b expected 0", din_ready); end
    @(negedge clk);
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b expected 1", din_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL idle_hold: %0d bad cycles expected 0", idle_bad); end
  endtask

  task automatic test_no_parity();
    logic [0:9] e;
    e = 10'b0101001011;
    start_word(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(42, -1, 8'h00, -1);
    for (int i = 0; i < 40; i++) begin
      total++;
      if (cap_tx[i] !== e[i/4] || cap_done[i] !== 1'b0) begin
        bad++; $display("FAIL np_bit%0d: tx=%b done=%b expected tx=%b done=0", i, cap_tx[i], cap_done[i], e[i/4]);
      end
    end
    total++; if (cap_rdy[0] !== 1'b0 || cap_busy[0] !== 1'b1) begin bad++; $display("FAIL np_busy: ready=%b busy=%b expected 0/1", cap_rdy[0], cap_busy[0]); end
    total++; if (cap_done[40] !== 1'b1) begin bad++; $display("FAIL np_done: got %b expected 1", cap_done[40]); end
    total++; if (cap_rdy[40] !== 1'b1 || cap_busy[40] !== 1'b0 || cap_tx[40] !== 1'b1) begin
      bad++; $display("FAIL np_idle: ready=%b busy=%b tx=%b expected 1/0/1", cap_rdy[40], cap_busy[40], cap_tx[40]);
    end
    total++; if (cap_done[41] !== 1'b0 || cap_tx[41] !== 1'b1) begin bad++; $display("FAIL np_pulse: done=%b tx=%b expected 0/1", cap_done[41], cap_tx[41]); end
  endtask

  task automatic test_parity();
    logic [0:10] e;
    for (int m = 0; m < 2; m++) begin
      e = (m == 0) ? 11'b01010010101 : 11'b01010010111;
      start_word(8'hA5, (m == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
      capture(45, -1, 8'h00, -1);
      for (int i = 0; i < 44; i++) begin
        total++;
        if (cap_tx[i] !== e[i/4]) begin
          bad++; $display("FAIL par%0d_bit%0d: tx=%b expected %b", m, i, cap_tx[i], e[i/4]);
        end
      end
      total++; if (cap_done[43] !== 1'b0 || cap_done[44] !== 1'b1) begin
        bad++; $display("FAIL par%0d_done: done43=%b done44=%b expected 0/1", m, cap_done[43], cap_done[44]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:10] e1, e2;
    e1 = 11'b00011110011;
    e2 = 11'b01000000111;
    start_word(8'h3C, 2'b00, 1'b1, 1'b1);
    capture(90, 10, 8'h81, 45);
    for (int i = 0; i < 44; i++) begin
      total++;
      if (cap_tx[i] !== e1[i/4]) begin bad++; $display("FAIL b2b_w1_%0d: tx=%b expected %b", i, cap_tx[i], e1[i/4]); end
    end
    total++; if (cap_done[44] !== 1'b1 || cap_tx[44] !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: done=%b tx=%b expected 1/1", cap_done[44], cap_tx[44]);
    end
    for (int i = 45; i < 89; i++) begin
      total++;
      if (cap_tx[i] !== e2[(i-45)/4]) begin bad++; $display("FAIL b2b_w2_%0d: tx=%b expected %b", i, cap_tx[i], e2[(i-45)/4]); end
    end
    total++; if (cap_done[88] !== 1'b0 || cap_done[89] !== 1'b1) begin
      bad++; $display("FAIL b2b_done2: done88=%b done89=%b expected 0/1", cap_done[88], cap_done[89]);
    end
  endtask

  task automatic test_mid_reset();
    logic [0:9] e;
    int post_bad = 0;
    e = 10'b0001111001;
    start_word(8'hA5, 2'b00, 1'b0, 1'b0);
    capture(18, -1, 8'h00, -1);
    total++; if (cap_tx[17] !== 1'b0) begin bad++; $display("FAIL mr_bit3: tx=%b expected 0", cap_tx[17]); end
    #2 reset = 1'b1;
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b0 || tx_done !== 1'b0) begin
      bad++; $display("FAIL mr_async: tx=%b busy=%b ready=%b done=%b expected 1/0/0/0", tx, busy, din_ready, tx_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    capture(10, -1, 8'h00, -1);
    for (int i = 0; i < 10; i++) if (cap_done[i] !== 1'b0 || cap_tx[i] !== 1'b1) post_bad++;
    total++; if (post_bad !== 0) begin bad++; $display("FAIL mr_quiet: %0d bad cycles expected 0", post_bad); end
    start_word(8'h3C, 2'b00, 1'b0, 1'b0);
    capture(41, -1, 8'h00, -1);
    for (int i = 0; i < 40; i++) begin
      total++;
      if (cap_tx[i] !== e[i/4]) begin bad++; $display("FAIL mr_next_%0d: tx=%b expected %b", i, cap_tx[i], e[i/4]); end
    end
    total++; if (cap_done[40] !== 1'b1) begin bad++; $display("FAIL mr_next_done: got %b expected 1", cap_done[40]); end
  endtask

  task automatic test_small();
    logic [0:8] e;
    logic       stx [0:19];
    logic       sdn [0:19];
    int w = 0;
    e = 9'b011001011;
    while (b_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL sm_ready: got %b expected 1", b_ready); end
    b_din = 5'h13; b_pm = 2'b10; b_ts = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    #1 b_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stx[i] = b_tx; sdn[i] = b_done;
    end
    for (int i = 0; i < 18; i++) begin
      total++;
      if (stx[i] !== e[i/2]) begin bad++; $display("FAIL sm_bit%0d: tx=%b expected %b", i, stx[i], e[i/2]); end
    end
    total++; if (sdn[17] !== 1'b0 || sdn[18] !== 1'b1) begin
      bad++; $display("FAIL sm_done: done17=%b done18=%b expected 0/1", sdn[17], sdn[18]);
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int low_bad = 0;
    @(negedge clk);
    brk_req = 1'b1; din = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; din_valid = 1'b1;
    @(posedge clk);
    #1 brk_req = 1'b0;
    capture(54, -1, 8'h00, 53);
    for (int i = 0; i < 52; i++) if (cap_tx[i] !== 1'b0 || cap_rdy[i] !== 1'b0 || cap_busy[i] !== 1'b1) low_bad++;
    total++; if (low_bad !== 0) begin bad++; $display("FAIL brk_low: %0d bad cycles expected 0", low_bad); end
    total++; if (cap_done[51] !== 1'b0 || cap_done[52] !== 1'b1 || cap_rdy[52] !== 1'b1 || cap_tx[52] !== 1'b1) begin
      bad++; $display("FAIL brk_end: done51=%b done52=%b ready=%b tx=%b expected 0/1/1/1", cap_done[51], cap_done[52], cap_rdy[52], cap_tx[52]);
    end
    total++; if (cap_tx[53] !== 1'b0) begin bad++; $display("FAIL brk_accept: tx=%b expected 0", cap_tx[53]); end
    capture(45, -1, 8'h00, -1);
    total++; if (cap_tx[3] !== 1'b1 || cap_done[39] !== 1'b1) begin
      bad++; $display("FAIL brk_word: bit0=%b done=%b expected 1/1", cap_tx[3], cap_done[39]);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    din = '0; din_valid = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
    b_din = '0; b_valid = 1'b0; b_pm = 2'b00; b_ts = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_req = 1'b0; b_brk = 1'b0;
`endif
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_mid_reset();
    test_small();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
